cv32e40p_hwloop_jump_ctrl: RTL and testbench
============================================

Name: cv32e40p_hwloop_jump_ctrl

Overview:
- Sits directly downstream of the hardware-loop register file. It consumes the per-loop start, end and counter values and detects when the ID-stage instruction is the last one of an active loop.
- It drives the per-loop counter-decrement strobes back to the register file.
- It issues a registered, held jump request with a target address to the IF stage. The request is kept until IF accepts it or a flush cancels it.

Parameters:
- N_REGS, 2, number of hardware-loop register sets. Index 0 is the innermost loop and has the highest priority.
- N_REG_BITS, $clog2(N_REGS), width of a loop index.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pc_id_i  input  32  PC of the instruction currently in ID
- id_valid_i  input  1  ID instruction retires this cycle. This is the same strobe that gates decrements in the register file.
- flush_i  input  1  controller kill (branch, exception, debug). Cancels pending loop actions.
- if_ready_i  input  1  IF can accept a redirect this cycle
- hwlp_start_addr_i  input  N_REGS x 32  loop start addresses
- hwlp_end_addr_i  input  N_REGS x 32  loop end addresses. Each is the address of the last loop instruction + 4.
- hwlp_counter_i  input  N_REGS x 32  remaining iteration counts
- hwlp_dec_cnt_o  output  N_REGS  one-hot decrement request to the register file
- hwlp_jump_o  output  1  registered redirect request to IF
- hwlp_targ_addr_o  output  32  redirect target; valid while hwlp_jump_o=1
- hwlp_pending_o  output  1  high while in PEND; lets the controller stall ID

Behaviour:
- Clock and reset: one clock `clk`. `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - hwlp_jump_o=0
  - hwlp_targ_addr_o=0
  - hwlp_pending_o=0
  - hwlp_dec_cnt_o=0
- Loop k matches when both hold:
  - pc_id_i == hwlp_end_addr_i[k] - 4, computed as 32-bit modulo arithmetic (end=0 gives 0xFFFFFFFC);
  - hwlp_counter_i[k] != 0.
- Selection:
  - The lowest matching index wins. At most one loop is selected per cycle.
  - Loops sharing an end address are unsupported by software convention. Only the inner loop is serviced.
- hwlp_dec_cnt_o is combinational: bit sel = match_sel & (state==IDLE) & ~flush_i. All other bits are 0.
  - The register file applies the decrement only on id_valid_i, so the strobe may stay high during ID stalls.
  - The block never asserts more than one bit.
- Jump decision, evaluated in IDLE on a cycle with id_valid_i=1, flush_i=0 and a selected loop:
  - hwlp_counter_i[sel] > 1: latch hwlp_start_addr_i[sel] into targ and move to PEND.
  - hwlp_counter_i[sel] == 1: last iteration. The counter is decremented to 0, there is no jump, and the state stays IDLE.
  - The decision uses the pre-decrement counter value, i.e. the value sampled in the same cycle as id_valid_i.
- Latency: hwlp_jump_o rises exactly one cycle after the retiring end instruction.
- States:
  - IDLE: hwlp_jump_o=0. Transitions as above.
  - PEND: hwlp_jump_o=1, hwlp_pending_o=1, target held stable.
    - if_ready_i=1 and flush_i=0: the jump is accepted this cycle; next state IDLE.
    - flush_i=1: the jump is dropped regardless of if_ready_i; next state IDLE.
    - Otherwise: stay in PEND.
    - id_valid_i in PEND is ignored and no decrement is issued, because the controller stalls ID.
- Simultaneous events:
  - flush_i with id_valid_i in IDLE: no decrement and no jump.
  - A counter write by the register file in the same cycle: ignored by this block. The register file gives the write priority.
- Reset mid-PEND: returns to IDLE immediately and the jump is lost.

Optional Feature:
- Macro: CV32E40P_HWLP_CHECK_EN.
- When defined, the block adds output `hwlp_err_o` (1 bit, reset 0). It is a sticky flag set on the first retirement of a selected loop in which any of these holds:
  - hwlp_end_addr_i[sel] <= hwlp_start_addr_i[sel] (unsigned);
  - end - start < 8;
  - pc_id_i[1:0] != 0.
- The flag clears only on reset. Loop behaviour is unchanged.
- When not defined, the port and all check logic are absent.

Test Plan:
1. start0=0x100, end0=0x110, cnt0=3; pc=0x10C with id_valid -> dec_cnt=01 that cycle; next cycle jump_o=1, targ=0x100, pending=1; with if_ready=1 -> IDLE after one cycle.
2. Same loop with cnt0=1; pc=0x10C retires -> dec_cnt=01; jump_o stays 0 for all following cycles; state stays IDLE.
3. cnt0=5, retire end instruction, if_ready=0 for 3 cycles then 1 -> jump_o=1 for 4 cycles with targ=0x100 constant; id_valid pulses during PEND give dec_cnt=00.
4. Enter PEND, assert flush_i with if_ready=0 -> jump_o=0 next cycle, IDLE; flush_i together with id_valid at the end instruction in IDLE -> dec_cnt=00, no PEND.
5. Nested: loop0 end 0x120, cnt0=2; loop1 end 0x140, cnt1=4; pc=0x11C -> dec_cnt=01, targ=start0; pc=0x13C -> dec_cnt=10, targ=start1; end1=0 with pc=0xFFFFFFFC -> match on loop1 (wrap).
6. With CV32E40P_HWLP_CHECK_EN: start0=0x200, end0=0x200, cnt0=2, pc=0x1FC retires -> hwlp_err_o=1 next cycle and stays 1 until rst_n=0.

Source files
------------

// File: rtl/cv32e40p_hwloop_jump_ctrl.sv
// Hardware-loop end detection and jump request generation.
// Watches the ID-stage PC against each loop's end address, strobes the
// counter decrement back to the loop register file and raises a held,
// registered redirect request towards IF.
// Optional build macro: CV32E40P_HWLP_CHECK_EN adds a sticky loop-setup
// error flag (hwlp_err_o).
module cv32e40p_hwloop_jump_ctrl #(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              pc_id_i,
    input  logic                     id_valid_i,
    input  logic                     flush_i,
    input  logic                     if_ready_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
    output logic [N_REGS-1:0]        hwlp_dec_cnt_o,
    output logic                     hwlp_jump_o,
    output logic [31:0]              hwlp_targ_addr_o,
    output logic                     hwlp_pending_o
`ifdef CV32E40P_HWLP_CHECK_EN
    ,
    output logic                     hwlp_err_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e                state_q;
    logic                  jump_q;
    logic                  pending_q;
    logic [31:0]           targ_q;

    logic [N_REGS-1:0]     match;
    logic                  match_any;
    logic [N_REG_BITS-1:0] sel;
    logic                  retire_sel;

    // Per-loop match: ID PC is the last loop instruction and iterations remain
    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            match[k] = (pc_id_i == (hwlp_end_addr_i[k] - 32'd4)) &&
                       (hwlp_counter_i[k] != 32'd0);
        end
    end

    // Priority select: scanning downwards lets the lowest (innermost) index win
    always_comb begin
        match_any = 1'b0;
        sel       = '0;
        for (int unsigned k = N_REGS; k > 0; k--) begin
            if (match[k-1]) begin
                match_any = 1'b1;
                sel       = N_REG_BITS'(k - 1);
            end
        end
    end

    // Decrement strobe; the register file itself qualifies it with id_valid_i
    always_comb begin
        hwlp_dec_cnt_o = '0;
        if (match_any && (state_q == IDLE) && !flush_i) begin
            hwlp_dec_cnt_o[sel] = 1'b1;
        end
    end

    assign retire_sel = (state_q == IDLE) && id_valid_i && !flush_i && match_any;

    // Jump FSM with registered request, pending flag and held target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            jump_q    <= 1'b0;
            pending_q <= 1'b0;
            targ_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (retire_sel && (hwlp_counter_i[sel] > 32'd1)) begin
                        state_q   <= PEND;
                        jump_q    <= 1'b1;
                        pending_q <= 1'b1;
                        targ_q    <= hwlp_start_addr_i[sel];
                    end
                end
                PEND: begin
                    if (flush_i || if_ready_i) begin
                        state_q   <= IDLE;
                        jump_q    <= 1'b0;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    jump_q    <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign hwlp_jump_o      = jump_q;
    assign hwlp_pending_o   = pending_q;
    assign hwlp_targ_addr_o = targ_q;

`ifdef CV32E40P_HWLP_CHECK_EN
    logic err_q;
    logic bad_setup;

    // Malformed loop: empty/inverted range, body shorter than two words, or misaligned PC
    always_comb begin
        bad_setup = (hwlp_end_addr_i[sel] <= hwlp_start_addr_i[sel]) ||
                    ((hwlp_end_addr_i[sel] - hwlp_start_addr_i[sel]) < 32'd8) ||
                    (pc_id_i[1:0] != 2'b00);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (retire_sel && bad_setup) begin
            err_q <= 1'b1;
        end
    end

    assign hwlp_err_o = err_q;
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_jump_ctrl.sv
// Directed self-checking bench for cv32e40p_hwloop_jump_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_cv32e40p_hwloop_jump_ctrl;

    logic              clk;
    logic              rst_n;
    logic [31:0]       pc_id;
    logic              id_valid;
    logic              flush;
    logic              if_ready;
    logic [1:0][31:0]  start_addr;
    logic [1:0][31:0]  end_addr;
    logic [1:0][31:0]  counter;
    logic [1:0]        dec_cnt;
    logic              jump;
    logic [31:0]       targ;
    logic              pending;
`ifdef CV32E40P_HWLP_CHECK_EN
    logic              err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cv32e40p_hwloop_jump_ctrl #(
        .N_REGS (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_id_i           (pc_id),
        .id_valid_i        (id_valid),
        .flush_i           (flush),
        .if_ready_i        (if_ready),
        .hwlp_start_addr_i (start_addr),
        .hwlp_end_addr_i   (end_addr),
        .hwlp_counter_i    (counter),
        .hwlp_dec_cnt_o    (dec_cnt),
        .hwlp_jump_o       (jump),
        .hwlp_targ_addr_o  (targ),
        .hwlp_pending_o    (pending)
`ifdef CV32E40P_HWLP_CHECK_EN
        ,
        .hwlp_err_o        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Retire the instruction at pc this cycle, check the strobe, then advance
    task automatic retire(input logic [31:0] pc, input logic [1:0] exp_dec, input string tag);
        pc_id    = pc;
        id_valid = 1'b1;
        #1;
        chk_eq(tag, {30'd0, dec_cnt}, {30'd0, exp_dec});
        tick();
        id_valid = 1'b0;
        pc_id    = 32'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        pc_id      = 32'h0;
        id_valid   = 1'b0;
        flush      = 1'b0;
        if_ready   = 1'b0;
        start_addr[0] = 32'h100; end_addr[0] = 32'h110; counter[0] = 32'd0;
        start_addr[1] = 32'h480; end_addr[1] = 32'h500; counter[1] = 32'd0;
        tick();
        tick();
        chk_eq("rst_jump",    {31'd0, jump},    32'd0);
        chk_eq("rst_pending", {31'd0, pending}, 32'd0);
        chk_eq("rst_targ",    targ,             32'h0);
        chk_eq("rst_dec",     {30'd0, dec_cnt}, 32'd0);
`ifdef CV32E40P_HWLP_CHECK_EN
        chk_eq("rst_err",     {31'd0, err},     32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: basic jump, accepted immediately
        counter[0] = 32'd3;
        retire(32'h10C, 2'b01, "t1_dec");
        if_ready = 1'b1;
        #1;
        chk_eq("t1_jump",    {31'd0, jump},    32'd1);
        chk_eq("t1_targ",    targ,             32'h100);
        chk_eq("t1_pending", {31'd0, pending}, 32'd1);
        tick();
        if_ready = 1'b0;
        chk_eq("t1_jump_clr", {31'd0, jump},    32'd0);
        chk_eq("t1_pend_clr", {31'd0, pending}, 32'd0);

        // 2: last iteration, no jump
        counter[0] = 32'd1;
        retire(32'h10C, 2'b01, "t2_dec");
        chk_eq("t2_jump0", {31'd0, jump}, 32'd0);
        tick();
        chk_eq("t2_jump1", {31'd0, jump},    32'd0);
        chk_eq("t2_pend1", {31'd0, pending}, 32'd0);

        // 3: IF stalls for three cycles, ID pulses ignored while pending
        counter[0] = 32'd5;
        retire(32'h10C, 2'b01, "t3_dec");
        for (int i = 0; i < 3; i++) begin
            pc_id    = 32'h10C;
            id_valid = 1'b1;
            #1;
            chk_eq($sformatf("t3_jump%0d", i), {31'd0, jump},    32'd1);
            chk_eq($sformatf("t3_targ%0d", i), targ,             32'h100);
            chk_eq($sformatf("t3_dec%0d",  i), {30'd0, dec_cnt}, 32'd0);
            tick();
        end
        id_valid = 1'b0;
        pc_id    = 32'h0;
        if_ready = 1'b1;
        #1;
        chk_eq("t3_jump3", {31'd0, jump}, 32'd1);
        chk_eq("t3_targ3", targ,          32'h100);
        tick();
        if_ready = 1'b0;
        chk_eq("t3_jump_clr", {31'd0, jump}, 32'd0);

        // 4: flush drops a pending jump; flush with retirement suppresses everything
        counter[0] = 32'd3;
        retire(32'h10C, 2'b01, "t4_dec");
        chk_eq("t4_jump", {31'd0, jump}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("t4_jump_flush", {31'd0, jump},    32'd0);
        chk_eq("t4_pend_flush", {31'd0, pending}, 32'd0);
        flush = 1'b1;
        retire(32'h10C, 2'b00, "t4_dec_flush");
        flush = 1'b0;
        chk_eq("t4_nojump", {31'd0, jump},    32'd0);
        chk_eq("t4_nopend", {31'd0, pending}, 32'd0);

        // 5: nested loops, priority, zero counter and end-address wrap
        start_addr[0] = 32'h100; end_addr[0] = 32'h120; counter[0] = 32'd2;
        start_addr[1] = 32'h0F0; end_addr[1] = 32'h140; counter[1] = 32'd4;
        retire(32'h11C, 2'b01, "t5_dec0");
        chk_eq("t5_targ0", targ, 32'h100);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        retire(32'h13C, 2'b10, "t5_dec1");
        chk_eq("t5_jump1", {31'd0, jump}, 32'd1);
        chk_eq("t5_targ1", targ,          32'h0F0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        end_addr[1] = 32'h120;
        retire(32'h11C, 2'b01, "t5_prio");
        chk_eq("t5_prio_targ", targ, 32'h100);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        counter[0] = 32'd0;
        counter[1] = 32'd0;
        retire(32'h11C, 2'b00, "t5_cnt_zero");
        chk_eq("t5_cnt_zero_jump", {31'd0, jump}, 32'd0);
        counter[1] = 32'd4;
        end_addr[1] = 32'h0;
        retire(32'hFFFF_FFFC, 2'b10, "t5_wrap_dec");
        chk_eq("t5_wrap_jump", {31'd0, jump}, 32'd1);
        chk_eq("t5_wrap_targ", targ,          32'h0F0);

        // Reset while pending drops the jump asynchronously
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_jump", {31'd0, jump},    32'd0);
        chk_eq("rst_mid_pend", {31'd0, pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_eq("rst_mid_idle", {31'd0, jump}, 32'd0);

`ifdef CV32E40P_HWLP_CHECK_EN
        // 6: degenerate loop setup raises the sticky error
        counter[1] = 32'd0;
        start_addr[0] = 32'h200; end_addr[0] = 32'h200; counter[0] = 32'd2;
        chk_eq("t6_err_pre", {31'd0, err}, 32'd0);
        retire(32'h1FC, 2'b01, "t6_dec");
        chk_eq("t6_err_set", {31'd0, err}, 32'd1);
        if_ready = 1'b1;
        tick();
        tick();
        if_ready = 1'b0;
        chk_eq("t6_err_hold", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_err_rst", {31'd0, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
